// File: rtl/el2_dccm_wrbuf.sv
// DCCM store write buffer: in-order FIFO of ECC-encoded stores, drained when
// the DCCM port is free or when a drain is forced, with youngest-match load forwarding.
package el2_pkg;
  typedef struct packed {
    logic [7:0] DCCM_BITS;
    logic [7:0] DCCM_FDATA_WIDTH;
  } el2_param_t;

  localparam el2_param_t EL2_PARAM_DEFAULT = '{DCCM_BITS: 8'd16, DCCM_FDATA_WIDTH: 8'd39};
endpackage

module el2_dccm_wrbuf #(
  parameter el2_pkg::el2_param_t pt = el2_pkg::EL2_PARAM_DEFAULT,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            st_valid,
  output logic                            st_ready,
  input  logic [pt.DCCM_BITS-1:0]         st_addr,
  input  logic [pt.DCCM_FDATA_WIDTH-1:0]  st_data,
  input  logic                            ld_rden,
  input  logic [pt.DCCM_BITS-1:0]         ld_addr,
  output logic                            ld_hit,
  output logic [pt.DCCM_FDATA_WIDTH-1:0]  ld_fwd_data,
  output logic                            ld_stall,
  input  logic                            flush,
  output logic                            dccm_wren,
  output logic [pt.DCCM_BITS-1:0]         dccm_wr_addr_lo,
  output logic [pt.DCCM_FDATA_WIDTH-1:0]  dccm_wr_data_lo,
  output logic                            wb_empty,
  output logic                            wb_full
);

  localparam int unsigned AW = pt.DCCM_BITS;
  localparam int unsigned DW = pt.DCCM_FDATA_WIDTH;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [7:0]    starve_cnt;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic          push, pop, force_drain;
  logic          fwd_match;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign wb_empty    = (count == '0);
  assign wb_full     = (count == FULL_CNT);
  assign st_ready    = ~wb_full;
  assign push        = st_valid & st_ready;

  assign force_drain = wb_full | (starve_cnt == STARVE_MAX) | flush;
  assign dccm_wren   = ~wb_empty & (~ld_rden | force_drain);
  assign pop         = dccm_wren;
  assign ld_stall    = ld_rden & dccm_wren;

  assign dccm_wr_addr_lo = dccm_wren ? addr_q[rd_ptr] : '0;
  assign dccm_wr_data_lo = dccm_wren ? data_q[rd_ptr] : '0;

  // Scan oldest to youngest so the last match wins; the head being drained
  // still counts as valid, a same-cycle push is not yet in the array.
  always_comb begin
    fwd_match = 1'b0;
    fwd_data  = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (((PW+1)'(k) < count) && ((addr_q[idx] >> 2) == (ld_addr >> 2))) begin
        fwd_match = 1'b1;
        fwd_data  = data_q[idx];
      end
    end
  end

  assign ld_hit      = ld_rden & fwd_match;
  assign ld_fwd_data = ld_hit ? fwd_data : '0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= st_addr;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (wb_empty || dccm_wren)        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) data_q[wr_ptr] <= st_data;
  end

endmodule

// File: tb/tb_el2_dccm_wrbuf.sv
// Bench for el2_dccm_wrbuf: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_el2_dccm_wrbuf;

  localparam int AW    = 16;
  localparam int DW    = 39;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          st_valid, st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          ld_rden;
  logic [AW-1:0] ld_addr;
  logic          ld_hit, ld_stall, flush;
  logic [DW-1:0] ld_fwd_data;
  logic          dccm_wren;
  logic [AW-1:0] dccm_wr_addr_lo;
  logic [DW-1:0] dccm_wr_data_lo;
  logic          wb_empty, wb_full;

  always #5 clk = ~clk;

  el2_dccm_wrbuf #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_l(rst_l),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_rden(ld_rden), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
    .ld_stall(ld_stall), .flush(flush),
    .dccm_wren(dccm_wren), .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_data_lo(dccm_wr_data_lo),
    .wb_empty(wb_empty), .wb_full(wb_full)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   starve;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input logic lr, input logic [AW-1:0] la, input logic fl);
    logic          e_full, e_empty, e_force, e_wren, e_hit, e_push;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata, e_fwd;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_rden = lr; ld_addr = la; flush = fl;
    #1;
    e_full  = (q.size() == DEPTH);
    e_empty = (q.size() == 0);
    e_force = e_full || (starve == LIMIT) || fl;
    e_wren  = !e_empty && (!lr || e_force);
    e_waddr = e_wren ? q[0].a : '0;
    e_wdata = e_wren ? q[0].d : '0;
    e_hit   = 1'b0;
    e_fwd   = '0;
    if (lr) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if ((q[i].a >> 2) == (la >> 2)) begin
          e_hit = 1'b1;
          e_fwd = q[i].d;
          break;
        end
      end
    end
    chk("st_ready", st_ready, !e_full);
    chk("wb_empty", wb_empty, e_empty);
    chk("wb_full", wb_full, e_full);
    chk("dccm_wren", dccm_wren, e_wren);
    chk("dccm_wr_addr", dccm_wr_addr_lo, e_waddr);
    chk("dccm_wr_data", dccm_wr_data_lo, e_wdata);
    chk("ld_stall", ld_stall, lr && e_wren);
    chk("ld_hit", ld_hit, e_hit);
    chk("ld_fwd_data", ld_fwd_data, e_fwd);
    e_push = sv && !e_full;
    if (e_empty || e_wren) starve = 0;
    else if (starve < LIMIT) starve++;
    if (e_wren) void'(q.pop_front());
    if (e_push) q.push_back('{a: sa, d: sd});
  endtask

  task automatic idle(input logic lr);
    step(1'b0, '0, '0, lr, 16'h0900, 1'b0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 3 * DEPTH && q.size() > 0; i++) idle(1'b0);
    chk("drain_bound", q.size(), 0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    logic got;
    rst_l = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_rden = 1'b0; ld_addr = '0; flush = 1'b0;
    q.delete(); starve = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", st_ready, 1); chk("rst_empty", wb_empty, 1);
    chk("rst_full", wb_full, 0);   chk("rst_wren", dccm_wren, 0);
    @(posedge clk); #1 rst_l = 1'b1;

    // idle drain: push then write on the very next cycle
    step(1'b1, 16'h0010, 39'h55, 1'b0, '0, 1'b0);
    idle(1'b0);
    chk("idle_wren", dccm_wren, 1);
    chk("idle_addr", dccm_wr_addr_lo, 16'h0010);
    chk("idle_data", dccm_wr_data_lo, 39'h55);
    idle(1'b0);
    chk("idle_empty", wb_empty, 1);

    // full forces a drain even with a load holding the port
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0100 + 16'(4 * i), rnd_data(), 1'b1, 16'h0900, 1'b0);
    step(1'b1, 16'h0300, rnd_data(), 1'b1, 16'h0900, 1'b0);
    chk("full_full", wb_full, 1);  chk("full_ready", st_ready, 0);
    chk("full_wren", dccm_wren, 1); chk("full_addr", dccm_wr_addr_lo, 16'h0100);
    chk("full_stall", ld_stall, 1);
    idle(1'b1);
    chk("full_ready_after", st_ready, 1);
    drain_all();

    // starvation: exactly LIMIT write-less cycles with an entry buffered
    step(1'b1, 16'h0060, rnd_data(), 1'b1, 16'h0900, 1'b0);
    nw = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1'b1);
      if (dccm_wren) begin
        got = 1'b1;
        chk("starve_stall", ld_stall, 1);
        break;
      end
      nw++;
    end
    chk("starve_got", got, 1);
    chk("starve_gap", nw, 8);
    idle(1'b1);
    chk("starve_empty", wb_empty, 1);

    // forwarding picks the youngest word match
    step(1'b1, 16'h0020, 39'hAA, 1'b1, 16'h0900, 1'b0);
    step(1'b1, 16'h0024, 39'hBB, 1'b1, 16'h0900, 1'b0);
    step(1'b1, 16'h0020, 39'hCC, 1'b1, 16'h0900, 1'b0);
    step(1'b0, '0, '0, 1'b1, 16'h0022, 1'b0);
    chk("fwd_hit", ld_hit, 1); chk("fwd_data", ld_fwd_data, 39'hCC);
    step(1'b0, '0, '0, 1'b1, 16'h0028, 1'b0);
    chk("fwd_miss", ld_hit, 0); chk("fwd_miss_data", ld_fwd_data, 0);
    step(1'b0, '0, '0, 1'b1, 16'h0027, 1'b0);
    chk("fwd_bb", ld_fwd_data, 39'hBB);
    drain_all();

    // flush with a concurrent push: three writes in order
    step(1'b1, 16'h0040, rnd_data(), 1'b1, 16'h0900, 1'b0);
    step(1'b1, 16'h0044, rnd_data(), 1'b1, 16'h0900, 1'b0);
    step(1'b1, 16'h0048, rnd_data(), 1'b1, 16'h0900, 1'b1);
    chk("fl_w0", dccm_wr_addr_lo, 16'h0040); chk("fl_stall", ld_stall, 1);
    step(1'b0, '0, '0, 1'b1, 16'h0900, 1'b1);
    chk("fl_w1", dccm_wr_addr_lo, 16'h0044);
    step(1'b0, '0, '0, 1'b1, 16'h0900, 1'b1);
    chk("fl_w2", dccm_wr_addr_lo, 16'h0048);
    step(1'b0, '0, '0, 1'b1, 16'h0900, 1'b1);
    chk("fl_empty", wb_empty, 1); chk("fl_wren", dccm_wren, 0);

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0080 + 16'(4 * i), rnd_data(), 1'b1, 16'h0900, 1'b0);
    idle(1'b0);
    chk("rmid_wren_before", dccm_wren, 1);
    rst_l = 1'b0;
    #1;
    chk("rmid_wren", dccm_wren, 0); chk("rmid_empty", wb_empty, 1);
    chk("rmid_ready", st_ready, 1);
    q.delete(); starve = 0;
    @(posedge clk); #1 rst_l = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 50, 16'h0200 + 16'($urandom_range(0, 31)), rnd_data(),
           $urandom_range(0, 99) < 65, 16'h0200 + 16'($urandom_range(0, 31)),
           $urandom_range(0, 99) < 4);
    end
    drain_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
